// File: rtl/cprv_ram_burst_master.sv
// cprv_ram_burst_master: bursts words between a
// command/stream interface and a single-port RAM.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   cmd_valid_i/ready_o command handshake
//   cmd_write_i         1 = write burst, 0 = read burst
//   cmd_addr_i          start word address
//   cmd_len_i           beat count (0 = no RAM access)
//   wd_valid_i/ready_o  write-data stream in
//   wd_data_i           write-data payload
//   rd_valid_o/ready_i  read-data stream out
//   rd_data_o           read-data payload (FIFO head)
//   ram_valid_o/ready_i RAM request handshake
//   ram_w_en_o          request is a write
//   ram_addr_o          request word address
//   ram_wdata_o         request write data
//   ram_valid_i         RAM response strobe
//   ram_ready_o         response accept (always 1)
//   ram_rdata_i         RAM response data
//   busy_o              burst in progress
//   done_o              one-cycle burst completion
module cprv_ram_burst_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [DATA_WIDTH-1:0] wd_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  ram_valid_o,
  input  logic                  ram_ready_i,
  output logic                  ram_w_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic                  ram_valid_i,
  output logic                  ram_ready_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  beats_q;
  logic                  wr_q;
  logic                  out_q;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wp_q, rp_q;
  logic [1:0]            cnt_q;

  logic       cmd_hs;
  logic       req_hs;
  logic       rsp;
  logic       push;
  logic       pop;
  logic       last;
  logic       room;
  logic [2:0] fill;

  assign cmd_hs = cmd_valid_i & cmd_ready_o;
  assign req_hs = ram_valid_o & ram_ready_i;
  // Responses with nothing outstanding are
  // stale (e.g. from before a reset): ignore.
  assign rsp    = ram_valid_i & out_q;
  assign push   = rsp & ~wr_q;
  assign pop    = rd_valid_o & rd_ready_i;
  assign last   = beats_q == LEN_WIDTH'(1);

  // Only issue a read if its data is
  // guaranteed a FIFO slot on return.
  assign fill = {1'b0, cnt_q} + {2'b00, out_q};
  assign room = fill < 3'd2;

  assign ram_ready_o = 1'b1;
  assign ram_addr_o  = addr_q;
  assign rd_valid_o  = cnt_q != 2'd0;
  assign rd_data_o   = fifo_q[rp_q];
  assign done_o      = done_q;
  assign busy_o      = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    cmd_ready_o = 1'b0;
    wd_ready_o  = 1'b0;
    ram_valid_o = 1'b0;
    ram_w_en_o  = 1'b0;
    ram_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = ~rst;
        if (cmd_hs) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else if (cmd_write_i) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        ram_valid_o = wd_valid_i;
        wd_ready_o  = ram_ready_i;
        ram_w_en_o  = 1'b1;
        ram_wdata_o = wd_data_i;
        if (req_hs && last) begin
          state_d = DRAIN;
        end
      end
      RD: begin
        ram_valid_o = room;
        if (req_hs && last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_q && (wr_q || cnt_q == 2'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      beats_q <= '0;
      wr_q    <= 1'b0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr_i;
      beats_q <= cmd_len_i;
      wr_q    <= cmd_write_i;
    end else if (req_hs) begin
      addr_q  <= addr_q + ADDR_WIDTH'(1);
      beats_q <= beats_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else if (req_hs && !rsp) begin
      out_q <= 1'b1;
    end else if (rsp && !req_hs) begin
      out_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wp_q] <= ram_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        wp_q <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

endmodule

// File: doc/cprv_ram_burst_master.md
CPRV_RAM_BURST_MASTER -- requirements
Module: cprv_ram_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, RAM word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width in beats.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_valid_i in 1 / cmd_ready_o out 1, the command handshake.
REQ-007 SHALL have ports cmd_write_i in 1 (1 = write burst), cmd_addr_i in ADDR_WIDTH (start word), cmd_len_i in LEN_WIDTH (beat count).
REQ-008 SHALL have ports wd_valid_i in 1, wd_ready_o out 1, wd_data_i in DATA_WIDTH, the write-data stream.
REQ-009 SHALL have ports rd_valid_o out 1, rd_ready_i in 1, rd_data_o out DATA_WIDTH, the read-data stream.
REQ-010 SHALL have ports ram_valid_o out 1, ram_ready_i in 1, ram_w_en_o out 1, ram_addr_o out ADDR_WIDTH, ram_wdata_o out DATA_WIDTH, the RAM request side.
REQ-011 SHALL have ports ram_valid_i in 1, ram_ready_o out 1, ram_rdata_i in DATA_WIDTH, the RAM response side; the RAM answers every accepted request, read or write, one cycle after acceptance.
REQ-012 SHALL have ports busy_o out 1 and done_o out 1.

Function
REQ-013 A handshake SHALL complete on any rising edge where valid and ready are both 1; a held valid SHALL keep its payload stable until accepted.
REQ-014 FSM states SHALL be IDLE, RD, WR and DRAIN; busy_o SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, cmd_ready_o SHALL be 1; a command handshake SHALL latch addr, len and write.
REQ-016 From IDLE, a command with len 0 SHALL return to IDLE and pulse done_o the next cycle without issuing any RAM request.
REQ-017 From IDLE, a command with len != 0 SHALL go to WR if write = 1, else to RD.
REQ-018 ram_addr_o SHALL present the current beat address, which increments by 1 on each RAM request handshake and wraps modulo 2^ADDR_WIDTH.
REQ-019 The beat counter SHALL decrement on each RAM request handshake; acceptance of the last beat SHALL move the FSM to DRAIN.
REQ-020 In WR: ram_valid_o = wd_valid_i, wd_ready_o = ram_ready_i, ram_w_en_o = 1, ram_wdata_o = wd_data_i; these SHALL be combinational, zero-latency.
REQ-021 In RD: ram_w_en_o SHALL be 0.
REQ-022 In RD, ram_valid_o SHALL be 1 only when the read FIFO occupancy plus the outstanding count is less than 2.
REQ-023 The read FIFO SHALL be a 2-entry FIFO; rd_valid_o SHALL mean the FIFO is non-empty, and rd_data_o SHALL be its head.
REQ-024 ram_ready_o SHALL be constantly 1.
REQ-025 A write response, or a response arriving while the outstanding count is 0, SHALL be discarded.
REQ-026 A read response SHALL push ram_rdata_i into the FIFO in the cycle that ram_valid_i is 1.
REQ-027 The outstanding counter SHALL be 0..1: +1 on a request handshake, -1 on a response; both in the same cycle SHALL leave it unchanged.
REQ-028 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged, and SHALL be legal even when the FIFO is full.
REQ-029 DRAIN SHALL exit to IDLE when outstanding = 0, and also the FIFO is empty for a read burst; done_o SHALL pulse 1 cycle in the cycle after exit (IDLE).
REQ-030 Outside WR, wd_ready_o SHALL be 0; outside RD/WR, ram_valid_o SHALL be 0.
REQ-031 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-032 While rst is 1, the module SHALL be in state IDLE with FIFO empty, outstanding 0 and the address/beat registers 0.
REQ-033 While rst is 1, all of the following SHALL be 0: busy_o, done_o, rd_valid_o, ram_valid_o, wd_ready_o, cmd_ready_o.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no done_o.
REQ-035 A stray RAM response after reset SHALL be discarded per REQ-025.

Verification
REQ-036 Write burst addr 0x10, len 4, data A..D, ram_ready_i = 1 -> RAM writes 0x10..0x13 in 4 consecutive cycles; done_o 1 pulse; busy_o back to 0.
REQ-037 Read burst addr 0x7E, len 4, rd_ready_i = 1 -> requests to 0x7E, 0x7F, 0x00, 0x01 (wrap); rd_data_o returns them in order; done_o after the 4th pop.
REQ-038 Read burst len 6 with rd_ready_i held 0 for 10 cycles -> exactly 2 requests issued, then ram_valid_o = 0 until pops free space; all 6 words are delivered in order with no loss.
REQ-039 Command len 0 -> no ram_valid_o; done_o asserts the cycle after the handshake.
REQ-040 rst pulsed during beat 2 of a len-5 read -> all outputs go to their reset values immediately; the stale response is dropped; a new len-1 read then completes normally.
REQ-041 Write burst with wd_valid_i toggling and ram_ready_i random -> exactly len RAM writes occur, with addresses sequential and data matching the stream.
